controle_multiciclo: RTL
========================

// Module: controle_multiciclo
// PURPOSE
//  Multicycle control FSM; sits directly upstream of the data-memory stage and drives its estado/memread/memwrite.
//  Sequences every instruction through IF/ID/EX/MEM/WB, decoding opcode/funct3 from the instruction register.
//  Emits Moore control strobes for PC, IR, ALU, memory and register file; counts retired instructions.
// PARAMETERS
//  INSTRET_W  32  width of retired-instruction counter
//  MAX_INSTR  0   0 = unlimited; N>0 = enter HALT once instret reaches N
// PORTS
//  clk       in   1          system clock, all state on posedge
//  rst_n     in   1          asynchronous, active-low reset
//  opcode    in   7          instr[6:0]; stable from DECODE to end of instruction
//  funct3    in   3          instr[14:12]; same stability as opcode
//  zero      in   1          ALU zero flag; sampled in EXEC_BR
//  estado    out  4          current state encoding (table below)
//  irwrite   out  1          load instruction register
//  pcwrite   out  1          unconditional PC update
//  pcsrc     out  1          0 = PC+4, 1 = branch target
//  alusrc    out  1          ALU operand B: 0 = rs2, 1 = immediate
//  aluop     out  2          00 add, 01 sub/compare, 10 funct-decoded
//  memread   out  1          data-memory read strobe
//  memwrite  out  1          data-memory write strobe
//  regwrite  out  1          register-file write strobe
//  memtoreg  out  1          WB source: 0 = ALU result, 1 = memory data
//  halted    out  1          FSM is in HALT
//  illegal   out  1          sticky: HALT was entered by an unsupported opcode/funct3
//  instret   out  INSTRET_W  retired-instruction count
// BEHAVIOUR
//  States: 0000 FETCH, 0001 DECODE, 0010 EXEC_R, 0011 MEM_LW, 0100 WB_LW, 0101 EXEC_ADDR,
//   0110 MEM_SW, 0111 WB_ALU, 1000 EXEC_BR, 1001 EXEC_I, 1010 HALT; 1011-1111 unused -> HALT, illegal=1.
//  Transitions (one per clk):
//   FETCH->DECODE
//   DECODE: 0110011->EXEC_R, 0010011->EXEC_I, 0000011/0100011->EXEC_ADDR, 1100011->EXEC_BR, else HALT
//   EXEC_R->WB_ALU, EXEC_I->WB_ALU; EXEC_ADDR: load->MEM_LW, store->MEM_SW
//   MEM_LW->WB_LW; WB_LW, WB_ALU, MEM_SW, EXEC_BR->FETCH (retire); HALT->HALT until rst_n low.
//  Outputs are Moore, combinational from estado; all strobes not listed are 0:
//   FETCH irwrite=1, pcwrite=1, pcsrc=0 | EXEC_R aluop=10 | EXEC_I alusrc=1, aluop=10
//   EXEC_ADDR alusrc=1, aluop=00 | MEM_LW memread=1 | MEM_SW memwrite=1 | WB_LW regwrite=1, memtoreg=1
//   WB_ALU regwrite=1 | EXEC_BR aluop=01, pcsrc=1, pcwrite=branch_taken | HALT halted=1
//  Latency: R/I/BR/SW = 4 or 3 cycles (BR 3: FETCH, DECODE, EXEC_BR), LW 5, SW 4, R/I 4.
//  Retire: instret += 1 on every transition into FETCH from a retire state; wraps modulo 2^INSTRET_W.
//  MAX_INSTR>0: a retire that makes instret==MAX_INSTR goes to HALT instead of FETCH (illegal stays 0).
//  Reset: async on rst_n low -> estado=FETCH, instret=0, illegal=0; all strobes forced 0 while rst_n low
//   (gated), so no IR/PC/memory write during reset; reset mid-instruction abandons it without retiring.
//  branch_taken: funct3=000 -> zero. Branch with any other funct3 -> HALT from DECODE, illegal=1.
// CONFIGURATION
//  BRANCH_BNE_EN defined: opcode 1100011 with funct3=001 is legal; branch_taken = !zero.
//  BRANCH_BNE_EN undefined: funct3=001 branch is illegal (DECODE->HALT, illegal=1).
// TESTING
//  Reset release, opcode=0110011 -> estado 0000,0001,0010,0111,0000; regwrite=1 only in 0111; instret=1.
//  opcode=0000011 -> 0000,0001,0101,0011,0100,0000; memread=1 in 0011; memtoreg=regwrite=1 in 0100.
//  opcode=0100011 -> 0000,0001,0101,0110,0000; memwrite=1 exactly one cycle; regwrite never 1.
//  opcode=1100011, funct3=000, zero=1 -> pcwrite=1, pcsrc=1 in 1000; zero=0 -> pcwrite=0 in 1000.
//  opcode=1111111 -> HALT, halted=1, illegal=1, all strobes 0; rst_n low mid-MEM_SW -> memwrite=0, estado=0000, instret=0.
//  MAX_INSTR=3, three R-type instrs -> HALT after third WB_ALU, instret=3, illegal=0; BNE per macro setting.

Source files
------------

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM: sequences IF/ID/EX/MEM/WB, emits Moore control strobes, counts retirements.
// Optional feature: define BRANCH_BNE_EN to accept funct3=001 branches (taken when !zero).
module controle_multiciclo #(
    parameter int unsigned INSTRET_W = 32,
    parameter int unsigned MAX_INSTR = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    output logic [3:0]           estado,
    output logic                 irwrite,
    output logic                 pcwrite,
    output logic                 pcsrc,
    output logic                 alusrc,
    output logic [1:0]           aluop,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 regwrite,
    output logic                 memtoreg,
    output logic                 halted,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [3:0] {
        StFetch    = 4'b0000,
        StDecode   = 4'b0001,
        StExecR    = 4'b0010,
        StMemLw    = 4'b0011,
        StWbLw     = 4'b0100,
        StExecAddr = 4'b0101,
        StMemSw    = 4'b0110,
        StWbAlu    = 4'b0111,
        StExecBr   = 4'b1000,
        StExecI    = 4'b1001,
        StHalt     = 4'b1010
    } state_e;

    state_e               state_q, state_d;
    logic                 illegal_q, illegal_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic [INSTRET_W-1:0] instret_inc;
    logic                 retire;
    logic                 hit_max;
    logic                 br_legal;
    logic                 branch_taken;

`ifdef BRANCH_BNE_EN
    assign br_legal     = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign branch_taken = (funct3 == 3'b001) ? !zero : zero;
`else
    assign br_legal     = (funct3 == 3'b000);
    assign branch_taken = zero;
`endif

    assign instret_inc = instret_q + 1'b1;
    assign hit_max     = (MAX_INSTR != 0) && (instret_inc == INSTRET_W'(MAX_INSTR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        instret_d = instret_q;
        retire    = 1'b0;
        case (state_q)
            StFetch:    state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpR:              state_d = StExecR;
                    OpI:              state_d = StExecI;
                    OpLoad, OpStore:  state_d = StExecAddr;
                    OpBranch: begin
                        if (br_legal) begin
                            state_d = StExecBr;
                        end else begin
                            state_d   = StHalt;
                            illegal_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = StHalt;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StExecR, StExecI: state_d = StWbAlu;
            StExecAddr: state_d = (opcode == OpLoad) ? StMemLw : StMemSw;
            StMemLw:    state_d = StWbLw;
            StWbLw, StWbAlu, StMemSw, StExecBr: retire = 1'b1;
            StHalt:     state_d = StHalt;
            default: begin
                // Unreachable encodings recover into a sticky illegal halt.
                state_d   = StHalt;
                illegal_d = 1'b1;
            end
        endcase
        if (retire) begin
            instret_d = instret_inc;
            state_d   = hit_max ? StHalt : StFetch;
        end
    end

    always_comb begin
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        pcsrc    = 1'b0;
        alusrc   = 1'b0;
        aluop    = 2'b00;
        memread  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        memtoreg = 1'b0;
        halted   = 1'b0;
        case (state_q)
            StFetch: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
            end
            StExecR:  aluop = 2'b10;
            StExecI: begin
                alusrc = 1'b1;
                aluop  = 2'b10;
            end
            StExecAddr: alusrc = 1'b1;
            StMemLw:  memread = 1'b1;
            StMemSw:  memwrite = 1'b1;
            StWbLw: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            StWbAlu:  regwrite = 1'b1;
            StExecBr: begin
                aluop   = 2'b01;
                pcsrc   = 1'b1;
                pcwrite = branch_taken;
            end
            StHalt:   halted = 1'b1;
            default:  ;
        endcase
        // Gate everything while reset is held so no IR/PC/memory write can leak out.
        if (!rst_n) begin
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            pcsrc    = 1'b0;
            alusrc   = 1'b0;
            aluop    = 2'b00;
            memread  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            memtoreg = 1'b0;
            halted   = 1'b0;
        end
    end

    assign estado  = state_q;
    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule
